rx_loader: RTL

//  Receive-side counterpart of the memory-to-UART sender: takes bytes from the UART receiver
//  and writes them to consecutive byte addresses of a memory port, starting at address 0.

---
 rtl/rx_loader_pkg.sv | 13 +
 rtl/rx_loader_idle_timer.sv | 16 +
 rtl/rx_loader.sv | 78 +++++++
 3 files changed

// File: rtl/rx_loader_pkg.sv
// rx_loader_pkg: state encodings and link defaults shared by the UART loader blocks
package rx_loader_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        WRITE     = 3'd2,
        INCREMENT = 3'd3,
        DONE      = 3'd4,
        ABORT     = 3'd5
    } state_t;
    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned BAUD_RATE = 115_200;
endpackage

// File: rtl/rx_loader_idle_timer.sv
// idle_timer: saturating 32-bit idle counter that flags when the link has stalled too long
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic iClock,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [31:0] count;
    // count idle clocks, holding at all-ones rather than wrapping
    always_ff @(posedge iClock)
        if (clear) count <= '0;
        else if (enable && count != 32'hFFFF_FFFF) count <= count + 1'b1;
    assign expired = (TIMEOUT_CYCLES != 0) && (count == TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/rx_loader.sv
// rx_loader: writes bytes from the UART receiver to consecutive memory addresses from 0
module rx_loader
    import rx_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          NUM_BYTES      = 65535,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic [7:0]            iRxData,
    input  logic                  iRxDone,
    output logic [ADDR_WIDTH-1:0] oAddress,
    output logic [7:0]            oData,
    output logic                  oWrEn,
    output logic                  oBusy,
    output logic                  oFinished,
    output logic                  oTimeout,
    output logic                  oOverrun
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_BYTES - 1);
    state_t state, next;
    logic [ADDR_WIDTH-1:0] count;
    logic expired;
    logic last;
    assign last = count == LAST;
    // the idle counter restarts in IDLE and after each byte, and only runs while waiting with no byte
    idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .iClock (iClock),
        .clear  (!iReset || state == IDLE || state == INCREMENT),
        .enable (state == WAIT_BYTE && !iRxDone),
        .expired(expired)
    );
    // next-state decode; a byte arriving wins over a simultaneous timeout, unused codes fall to IDLE
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:      next = iStart ? WAIT_BYTE : IDLE;
            WAIT_BYTE: next = iRxDone ? WRITE : expired ? ABORT : WAIT_BYTE;
            WRITE:     next = INCREMENT;
            INCREMENT: next = last ? DONE : WAIT_BYTE;
            default:   next = IDLE;
        endcase
    end
    // state and output registers; strobes are decoded from next state so they coincide with their state
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state     <= IDLE;
            count     <= '0;
            oAddress  <= '0;
            oData     <= '0;
            oWrEn     <= 1'b0;
            oBusy     <= 1'b0;
            oFinished <= 1'b0;
            oTimeout  <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            state     <= next;
            oWrEn     <= next == WRITE;
            oBusy     <= next != IDLE;
            oFinished <= next == DONE;
            if (state == IDLE && iStart) begin
                count    <= '0;
                oAddress <= '0;
                oTimeout <= 1'b0;
                oOverrun <= 1'b0;
            end
            if (state == WAIT_BYTE && iRxDone) oData <= iRxData;
            if (state == INCREMENT && !last) begin
                count    <= count + 1'b1;
                oAddress <= oAddress + 1'b1;
            end
            if (next == ABORT) oTimeout <= 1'b1;
            if (iRxDone && state inside {WRITE, INCREMENT, DONE, ABORT}) oOverrun <= 1'b1;
        end
    end
endmodule
